// File: rtl/bypass_window_if.sv
// Bundle of writeback, lookup and status signals for the bypass window.
// The slave modport is the window itself; the master modport is its environment.
interface bypass_window_if #(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 6,
    parameter int DEPTH    = 3,
    parameter int WB_PORTS = 2,
    parameter int RD_PORTS = 4,
    parameter int SRC_W    = $clog2(DEPTH + 1),
    parameter int OCC_W    = $clog2(DEPTH * WB_PORTS + 1)
);
    logic                         flush_i;
    logic [WB_PORTS-1:0]          wb_valid_i;
    logic [WB_PORTS*TAG_W-1:0]    wb_tag_i;
    logic [WB_PORTS*DATA_W-1:0]   wb_data_i;
    logic [RD_PORTS*TAG_W-1:0]    rd_tag_i;
    logic [RD_PORTS-1:0]          rd_hit_o;
    logic [RD_PORTS*DATA_W-1:0]   rd_data_o;
    logic [RD_PORTS*SRC_W-1:0]    rd_src_o;
    logic [OCC_W-1:0]             occupancy_o;

    modport slave (
        input  flush_i, wb_valid_i, wb_tag_i, wb_data_i, rd_tag_i,
        output rd_hit_o, rd_data_o, rd_src_o, occupancy_o
    );

    modport master (
        output flush_i, wb_valid_i, wb_tag_i, wb_data_i, rd_tag_i,
        input  rd_hit_o, rd_data_o, rd_src_o, occupancy_o
    );
endinterface

// File: rtl/bypass_window.sv
// Retains WB_PORTS writeback results for DEPTH cycles and serves RD_PORTS
// zero-latency tag lookups, youngest match first, lowest channel within a level.
module bypass_window #(
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 6,
    parameter int DEPTH       = 3,
    parameter int WB_PORTS    = 2,
    parameter int RD_PORTS    = 4,
    parameter int ZERO_TAG_HW = 1,
    parameter int SRC_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    bypass_window_if.slave   bus
);
    localparam int OCC_W = $clog2(DEPTH * WB_PORTS + 1);

    logic [WB_PORTS-1:0] r_valid [DEPTH];
    logic [TAG_W-1:0]    r_tag   [DEPTH][WB_PORTS];
    logic [DATA_W-1:0]   r_data  [DEPTH][WB_PORTS];
    logic [OCC_W-1:0]    r_occ;

    logic [WB_PORTS-1:0]        w_cap_valid;
    logic [WB_PORTS-1:0]        w_live_valid;
    logic [OCC_W-1:0]           w_next_occ;
    logic [RD_PORTS-1:0]        w_hit;
    logic [RD_PORTS*DATA_W-1:0] w_rd_data;
    logic [RD_PORTS*SRC_W-1:0]  w_rd_src;

    // Tag 0 is dropped at capture so it can never be stored nor matched live.
    always_comb begin
        w_cap_valid = '0;
        for (int k = 0; k < WB_PORTS; k++) begin
            w_cap_valid[k] = bus.wb_valid_i[k] &
                             ~((ZERO_TAG_HW != 0) && (bus.wb_tag_i[k*TAG_W +: TAG_W] == '0));
        end
        w_live_valid = w_cap_valid & {WB_PORTS{~rst}};
    end

    always_comb begin
        w_next_occ = '0;
        for (int k = 0; k < WB_PORTS; k++) begin
            w_next_occ = w_next_occ + OCC_W'(w_cap_valid[k]);
        end
        for (int s = 0; s < DEPTH - 1; s++) begin
            for (int k = 0; k < WB_PORTS; k++) begin
                w_next_occ = w_next_occ + OCC_W'(r_valid[s][k]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) r_valid[s] <= '0;
            r_occ <= '0;
        end else if (bus.flush_i) begin
            for (int s = 0; s < DEPTH; s++) r_valid[s] <= '0;
            r_occ <= '0;
        end else begin
            r_valid[0] <= w_cap_valid;
            for (int s = 1; s < DEPTH; s++) r_valid[s] <= r_valid[s-1];
            r_occ <= w_next_occ;
        end
    end

    // Payload needs no reset: it is only ever qualified by r_valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WB_PORTS; k++) begin
            r_tag[0][k]  <= bus.wb_tag_i[k*TAG_W +: TAG_W];
            r_data[0][k] <= bus.wb_data_i[k*DATA_W +: DATA_W];
            for (int s = 1; s < DEPTH; s++) begin
                r_tag[s][k]  <= r_tag[s-1][k];
                r_data[s][k] <= r_data[s-1][k];
            end
        end
    end

    // Scan oldest-to-youngest and high-to-low channel so the last match written
    // is the youngest, lowest-channel one.
    always_comb begin
        w_hit     = '0;
        w_rd_data = '0;
        w_rd_src  = '0;
        for (int j = 0; j < RD_PORTS; j++) begin
            for (int s = DEPTH - 1; s >= 0; s--) begin
                for (int k = WB_PORTS - 1; k >= 0; k--) begin
                    if (r_valid[s][k] && (r_tag[s][k] == bus.rd_tag_i[j*TAG_W +: TAG_W])) begin
                        w_hit[j]                    = 1'b1;
                        w_rd_data[j*DATA_W +: DATA_W] = r_data[s][k];
                        w_rd_src[j*SRC_W +: SRC_W]    = SRC_W'(s + 1);
                    end
                end
            end
            for (int k = WB_PORTS - 1; k >= 0; k--) begin
                if (w_live_valid[k] &&
                    (bus.wb_tag_i[k*TAG_W +: TAG_W] == bus.rd_tag_i[j*TAG_W +: TAG_W])) begin
                    w_hit[j]                    = 1'b1;
                    w_rd_data[j*DATA_W +: DATA_W] = bus.wb_data_i[k*DATA_W +: DATA_W];
                    w_rd_src[j*SRC_W +: SRC_W]    = '0;
                end
            end
        end
    end

    assign bus.rd_hit_o    = w_hit;
    assign bus.rd_data_o   = w_rd_data;
    assign bus.rd_src_o    = w_rd_src;
    assign bus.occupancy_o = r_occ;
endmodule
